// File: rtl/ring_req_arbiter.sv
// Round-robin arbiter that shares one line-fill port between NUM_REQ cores.
// Optional watchdog abort of stalled transactions: define ARB_TIMEOUT_EN.
module ring_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int LINE_BEATS = 8,
    parameter int TIMEOUT    = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            core_en,
    input  logic [NUM_REQ-1:0]            c_req,
    input  logic [NUM_REQ*ADDR_W-1:0]     c_addr,
    output logic [NUM_REQ-1:0]            c_gnt,
    output logic [NUM_REQ-1:0]            c_rvalid,
    output logic [DATA_W-1:0]             c_rdata,
    output logic [$clog2(LINE_BEATS)-1:0] c_beat,
    output logic [NUM_REQ-1:0]            c_done,
    output logic                          m_req,
    output logic [ADDR_W-1:0]             m_addr,
    input  logic                          m_ack,
    input  logic                          m_rvalid,
    input  logic [DATA_W-1:0]             m_rdata,
    input  logic                          m_rlast,
    output logic                          err
);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BEAT_W = $clog2(LINE_BEATS);
    localparam int OFF_W  = $clog2(LINE_BEATS * DATA_W / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

    typedef enum logic [1:0] {IDLE, ISSUE, DATA, DONE} state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]    gidx_reg, gidx_next;
    logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
    logic [BEAT_W-1:0]   beat_reg, beat_next;
    logic                m_req_reg, m_req_next;
    logic [ADDR_W-1:0]   m_addr_reg, m_addr_next;
    logic                err_reg, err_next;

    logic [ADDR_W-1:0]   core_addr [NUM_REQ];
    logic [NUM_REQ-1:0]  elig;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    cand_idx;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
            assign core_addr[gi] = c_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    assign elig = c_req & core_en;

    // First eligible core at or after rr_ptr, scanning with wrap-around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = IDX_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
            if (!pick_found && elig[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd_reg, wd_next;
`endif

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        gidx_next   = gidx_reg;
        gnt_next    = gnt_reg;
        beat_next   = beat_reg;
        m_req_next  = m_req_reg;
        m_addr_next = m_addr_reg;
        err_next    = err_reg;
`ifdef ARB_TIMEOUT_EN
        wd_next     = '0;
`endif
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    gidx_next   = pick_idx;
                    gnt_next    = NUM_REQ'(1) << pick_idx;
                    m_addr_next = core_addr[pick_idx] & LINE_MASK;
                    m_req_next  = 1'b1;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                if (m_ack) begin
                    m_req_next = 1'b0;
                    state_next = DATA;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wd_reg == WD_LAST) begin
                    m_req_next = 1'b0;
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    wd_next = wd_reg + WD_W'(1);
                end
`endif
            end
            DATA: begin
                if (m_rvalid) begin
                    beat_next = beat_reg + BEAT_W'(1);
                    // Either end marker closes the line; disagreement is a protocol error.
                    if (m_rlast || beat_reg == LAST_BEAT) begin
                        state_next = DONE;
                        if (m_rlast != (beat_reg == LAST_BEAT))
                            err_next = 1'b1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (wd_reg == WD_LAST) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    wd_next = wd_reg + WD_W'(1);
                end
`endif
            end
            DONE: begin
                gnt_next    = '0;
                rr_ptr_next = (int'(gidx_reg) == NUM_REQ - 1) ? '0 : gidx_reg + IDX_W'(1);
                beat_next   = '0;
                m_addr_next = '0;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (m_rvalid && state_reg != DATA)
            err_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            gidx_reg   <= '0;
            gnt_reg    <= '0;
            beat_reg   <= '0;
            m_req_reg  <= 1'b0;
            m_addr_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            gidx_reg   <= gidx_next;
            gnt_reg    <= gnt_next;
            beat_reg   <= beat_next;
            m_req_reg  <= m_req_next;
            m_addr_reg <= m_addr_next;
            err_reg    <= err_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_reg <= '0;
        else        wd_reg <= wd_next;
    end
`endif

    assign c_gnt    = gnt_reg;
    assign c_rvalid = (state_reg == DATA && m_rvalid) ? gnt_reg : '0;
    assign c_rdata  = (state_reg == DATA && m_rvalid) ? m_rdata : '0;
    assign c_beat   = beat_reg;
    assign c_done   = (state_reg == DONE) ? gnt_reg : '0;
    assign m_req    = m_req_reg;
    assign m_addr   = m_addr_reg;
    assign err      = err_reg;
endmodule

// File: tb/tb_ring_req_arbiter.sv
// Scoreboard bench for ring_req_arbiter: expected beats queued as they are driven,
// compared against beats and c_done pulses captured from the core side.
module tb_ring_req_arbiter;
    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LB = 8;
    localparam int TO = 16;

    typedef logic [N+3+DW-1:0] beat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    core_en = '0;
    logic [N-1:0]    c_req = '0;
    logic [N*AW-1:0] c_addr = '0;
    logic [N-1:0]    c_gnt, c_rvalid, c_done;
    logic [DW-1:0]   c_rdata;
    logic [2:0]      c_beat;
    logic            m_req;
    logic [AW-1:0]   m_addr;
    logic            m_ack = 1'b0;
    logic            m_rvalid = 1'b0;
    logic [DW-1:0]   m_rdata = '0;
    logic            m_rlast = 1'b0;
    logic            err;

    ring_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LINE_BEATS(LB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .core_en(core_en), .c_req(c_req), .c_addr(c_addr),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_beat(c_beat), .c_done(c_done),
        .m_req(m_req), .m_addr(m_addr), .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .m_rlast(m_rlast), .err(err)
    );

    always #5 clk = ~clk;

    beat_t        exp_beat_q[$];
    beat_t        obs_beat_q[$];
    logic [N-1:0] obs_done_q[$];
    int tests_run = 0;
    int tests_failed = 0;
    int overlap_cnt = 0;
    int done_multi = 0;
    logic [N-1:0] prev_done = '0;

    // Core-side monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (|c_rvalid) obs_beat_q.push_back({c_rvalid, c_beat, c_rdata});
            if (|c_done) obs_done_q.push_back(c_done);
            if ($countones(c_gnt) > 1) overlap_cnt++;
            if (|c_done && |prev_done) done_multi++;
            prev_done = c_done;
        end else begin
            prev_done = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_ack = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;
        c_req = '0;
        tick(); tick();
        rst_n = 1'b1;
        exp_beat_q.delete(); obs_beat_q.delete(); obs_done_q.delete();
        overlap_cnt = 0; done_multi = 0;
        tick();
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        c_addr[i*AW +: AW] = a;
    endtask

    // Downstream model: waits for m_req, acks, then streams beats and queues expectations.
    task automatic serve(input int idx, input int ack_delay, input int nbeats, input int rlast_at,
                         input logic [DW-1:0] base, output logic [N-1:0] got_gnt,
                         output logic [AW-1:0] got_addr);
        int w = 0;
        while (m_req !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        tests_run++;
        if (m_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL req_seen core%0d: m_req=%b required 1 within 100 cycles", idx, m_req);
            got_gnt = '0;
            got_addr = '0;
            return;
        end
        got_gnt = c_gnt;
        got_addr = m_addr;
        repeat (ack_delay) tick();
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            m_rvalid = 1'b1;
            m_rdata = base + DW'(b);
            m_rlast = (b == rlast_at);
            exp_beat_q.push_back({N'(1) << idx, 3'(b), base + DW'(b)});
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;
        $display("[TB] txn core %0d gnt %b addr 0x%0h beats %0d", idx, got_gnt, got_addr, nbeats);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        tests_run++;
        if ({c_gnt, c_rvalid, c_done, m_req, err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: gnt=%b rvalid=%b done=%b m_req=%b err=%b required all 0",
                     c_gnt, c_rvalid, c_done, m_req, err);
        end
        tests_run++;
        if ({m_addr, c_rdata, c_beat} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: m_addr=%h rdata=%h beat=%0d required 0", m_addr, c_rdata, c_beat);
        end
    endtask

    task automatic test_single();
        logic [N-1:0] g; logic [AW-1:0] a; beat_t e, o;
        do_reset();
        core_en = 4'b1111;
        set_addr(0, 64'h1234);
        c_req = 4'b0001;
        serve(0, 2, 8, 7, 64'hA0, g, a);
        c_req = '0;
        repeat (4) tick();
        tests_run++;
        if (a !== 64'h1200) begin tests_failed++; $display("FAIL single_addr: m_addr=%h required 1200", a); end
        tests_run++;
        if (g !== 4'b0001) begin tests_failed++; $display("FAIL single_gnt: gnt=%b required 0001", g); end
        tests_run++;
        if (obs_beat_q.size() !== exp_beat_q.size()) begin
            tests_failed++;
            $display("FAIL single_beat_cnt: got %0d required %0d", obs_beat_q.size(), exp_beat_q.size());
        end
        while (exp_beat_q.size() > 0) begin
            e = exp_beat_q.pop_front();
            o = (obs_beat_q.size() > 0) ? obs_beat_q.pop_front() : 'x;
            tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL single_beat: got %h required %h", o, e); end
        end
        tests_run++;
        if (obs_done_q.size() != 1 || obs_done_q[0] !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_done: %0d pulses first=%b required 1 pulse 0001",
                     obs_done_q.size(), (obs_done_q.size() > 0) ? obs_done_q[0] : 4'bx);
        end
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL single_err: err=%b required 0", err); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g; logic [AW-1:0] a; beat_t e, o;
        int order [5] = '{0, 1, 2, 3, 0};
        logic [AW-1:0] addrs [N] = '{64'h1045, 64'h2085, 64'h30C5, 64'h4105};
        do_reset();
        core_en = 4'b1111;
        for (int i = 0; i < N; i++) set_addr(i, addrs[i]);
        c_req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            serve(order[t], 0, 8, 7, DW'(64'h100 * (t + 1)), g, a);
            tests_run++;
            if (g !== N'(1) << order[t]) begin
                tests_failed++;
                $display("FAIL rr_gnt txn%0d: gnt=%b required core %0d", t, g, order[t]);
            end
            tests_run++;
            if (a !== (addrs[order[t]] & ~64'h3F)) begin
                tests_failed++;
                $display("FAIL rr_addr txn%0d: m_addr=%h required %h", t, a, addrs[order[t]] & ~64'h3F);
            end
        end
        c_req = '0;
        repeat (4) tick();
        while (exp_beat_q.size() > 0) begin
            e = exp_beat_q.pop_front();
            o = (obs_beat_q.size() > 0) ? obs_beat_q.pop_front() : 'x;
            tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL rr_beat: got %h required %h", o, e); end
        end
        tests_run++;
        if (obs_done_q.size() != 5) begin
            tests_failed++;
            $display("FAIL rr_done_cnt: got %0d required 5", obs_done_q.size());
        end
        for (int t = 0; t < 5 && t < obs_done_q.size(); t++) begin
            tests_run++;
            if (obs_done_q[t] !== N'(1) << order[t]) begin
                tests_failed++;
                $display("FAIL rr_done txn%0d: got %b required core %0d", t, obs_done_q[t], order[t]);
            end
        end
        tests_run++;
        if (overlap_cnt != 0 || done_multi != 0) begin
            tests_failed++;
            $display("FAIL rr_overlap: overlap=%0d multi_done=%0d required 0 0", overlap_cnt, done_multi);
        end
    endtask

    task automatic test_enable_gate();
        logic [N-1:0] g; logic [AW-1:0] a;
        int order [3] = '{1, 2, 3};
        do_reset();
        core_en = 4'b0001;
        c_req = 4'b1110;
        repeat (20) tick();
        tests_run++;
        if (m_req !== 1'b0 || c_gnt !== '0) begin
            tests_failed++;
            $display("FAIL en_gate: m_req=%b gnt=%b required 0 0000", m_req, c_gnt);
        end
        core_en = 4'b1111;
        for (int t = 0; t < 3; t++) begin
            serve(order[t], 1, 8, 7, DW'(64'h200 + 16 * t), g, a);
            tests_run++;
            if (g !== N'(1) << order[t]) begin
                tests_failed++;
                $display("FAIL en_order txn%0d: gnt=%b required core %0d", t, g, order[t]);
            end
        end
        c_req = '0;
        repeat (4) tick();
        tests_run++;
        if (obs_done_q.size() != 3 || obs_beat_q.size() != 24) begin
            tests_failed++;
            $display("FAIL en_counts: done=%0d beats=%0d required 3 24", obs_done_q.size(), obs_beat_q.size());
        end
    endtask

    task automatic test_early_rlast();
        logic [N-1:0] g; logic [AW-1:0] a; beat_t e, o;
        do_reset();
        core_en = 4'b1111;
        c_req = 4'b0001;
        serve(0, 0, 6, 5, 64'hC0, g, a);
        c_req = '0;
        repeat (3) tick();
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL early_err: err=%b required 1", err); end
        tests_run++;
        if (obs_done_q.size() != 1 || obs_done_q[0] !== 4'b0001) begin
            tests_failed++;
            $display("FAIL early_done: %0d pulses required 1 to core 0", obs_done_q.size());
        end
        c_req = 4'b0010;
        serve(1, 0, 8, 7, 64'hD0, g, a);
        c_req = '0;
        repeat (3) tick();
        tests_run++;
        if (g !== 4'b0010) begin tests_failed++; $display("FAIL early_next_gnt: gnt=%b required 0010", g); end
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL early_sticky: err=%b required 1", err); end
        tests_run++;
        if (obs_done_q.size() != 2 || obs_done_q[1] !== 4'b0010) begin
            tests_failed++;
            $display("FAIL early_next_done: %0d pulses required 2 ending core 1", obs_done_q.size());
        end
        tests_run++;
        if (obs_beat_q.size() !== exp_beat_q.size()) begin
            tests_failed++;
            $display("FAIL early_beat_cnt: got %0d required %0d", obs_beat_q.size(), exp_beat_q.size());
        end
        while (exp_beat_q.size() > 0) begin
            e = exp_beat_q.pop_front();
            o = (obs_beat_q.size() > 0) ? obs_beat_q.pop_front() : 'x;
            tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL early_beat: got %h required %h", o, e); end
        end
    endtask

    task automatic test_reset_midflight();
        logic [N-1:0] g; logic [AW-1:0] a;
        do_reset();
        core_en = 4'b1111;
        c_req = 4'b0001;
        serve(0, 0, 3, 99, 64'hE0, g, a);
        m_rvalid = 1'b1;
        m_rdata = 64'hE3;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({c_gnt, c_rvalid, c_done, m_req, err} !== '0) begin
            tests_failed++;
            $display("FAIL midrst_ctrl: gnt=%b rvalid=%b done=%b m_req=%b err=%b required 0",
                     c_gnt, c_rvalid, c_done, m_req, err);
        end
        tests_run++;
        if ({c_rdata, c_beat, m_addr} !== '0) begin
            tests_failed++;
            $display("FAIL midrst_data: rdata=%h beat=%0d m_addr=%h required 0", c_rdata, c_beat, m_addr);
        end
        tests_run++;
        if (obs_beat_q.size() != 3 || obs_done_q.size() != 0) begin
            tests_failed++;
            $display("FAIL midrst_partial: beats=%0d done=%0d required 3 0", obs_beat_q.size(), obs_done_q.size());
        end
        m_rvalid = 1'b0;
        m_rdata = '0;
        c_req = 4'b0011;
        tick(); tick();
        rst_n = 1'b1;
        exp_beat_q.delete(); obs_beat_q.delete(); obs_done_q.delete();
        serve(0, 0, 8, 7, 64'hF0, g, a);
        c_req = '0;
        repeat (3) tick();
        tests_run++;
        if (g !== 4'b0001) begin tests_failed++; $display("FAIL midrst_first_gnt: gnt=%b required 0001", g); end
        tests_run++;
        if (obs_done_q.size() != 1 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_after: done=%0d err=%b required 1 0", obs_done_q.size(), err);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [N-1:0] g; logic [AW-1:0] a;
        int w = 0;
        int cnt = 0;
        do_reset();
        core_en = 4'b1111;
        c_req = 4'b0011;
        while (m_req !== 1'b1 && w < 50) begin tick(); w++; end
        while (m_req === 1'b1 && cnt < 100) begin cnt++; tick(); end
        tests_run++;
        if (cnt != TO) begin tests_failed++; $display("FAIL to_req_cycles: got %0d required %0d", cnt, TO); end
        serve(1, 0, 8, 7, 64'h300, g, a);
        c_req = '0;
        repeat (3) tick();
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL to_err: err=%b required 1", err); end
        tests_run++;
        if (g !== 4'b0010) begin tests_failed++; $display("FAIL to_next_gnt: gnt=%b required 0010", g); end
        tests_run++;
        if (obs_done_q.size() != 2 || obs_done_q[0] !== 4'b0001) begin
            tests_failed++;
            $display("FAIL to_done: %0d pulses required 2 starting core 0", obs_done_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_enable_gate();
        test_early_rlast();
        test_reset_midflight();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ring_req_arbiter.md
Name: ring_req_arbiter

Overview:
- Round-robin arbiter that shares the single supercore ring/L2 line-fill port between NUM_REQ cores.
- Accepts per-core line read requests, gated by core enable.
- Issues one outstanding line request downstream and steers the returned data beats to the granted core.
- Sits between the core ring interfaces and the L2/ring fill controller.

Parameters:
- NUM_REQ, 4, number of requesting cores (2..8)
- ADDR_W, 64, request address width
- DATA_W, 64, data beat width
- LINE_BEATS, 8, beats per cache line (power of two, >=2)
- TIMEOUT, 256, watchdog cycle limit per beat (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- core_en  in  NUM_REQ  per-core enable; a request from a disabled core is ignored
- c_req  in  NUM_REQ  per-core level request; held until that core's c_done pulse
- c_addr  in  NUM_REQ*ADDR_W  flattened request addresses, core i at bits [i*ADDR_W +: ADDR_W]
- c_gnt  out  NUM_REQ  one-hot grant to the core currently being served
- c_rvalid  out  NUM_REQ  one-hot beat-valid for the granted core
- c_rdata  out  DATA_W  shared beat data
- c_beat  out  log2(LINE_BEATS)  index of the current beat
- c_done  out  NUM_REQ  one-cycle pulse to the granted core after its last beat
- m_req  out  1  downstream line request
- m_addr  out  ADDR_W  line-aligned address: low log2(LINE_BEATS*DATA_W/8) bits forced to 0
- m_ack  in  1  downstream accepts the request; handshake completes on m_req && m_ack
- m_rvalid  in  1  downstream beat valid
- m_rdata  in  DATA_W  downstream beat data
- m_rlast  in  1  final beat marker
- err  out  1  sticky protocol error flag; cleared only by reset

Behaviour:
- Reset (async assert, sync deassert at the design level):
  - All outputs are 0.
  - State = IDLE, rr_ptr = 0, beat counter = 0.
  - An in-flight transaction is dropped; no c_done is issued.
- States: IDLE, ISSUE, DATA, DONE.
- IDLE:
  - Eligible set = c_req & core_en.
  - Grant the first eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Register c_gnt and m_addr from that core's address; assert m_req; go to ISSUE next cycle.
  - No eligible request: stay in IDLE.
- ISSUE:
  - Hold m_req, m_addr and c_gnt stable until m_ack.
  - On m_ack: deassert m_req in the same edge update and go to DATA.
- DATA:
  - Each m_rvalid cycle forwards combinationally: c_rvalid = c_gnt, c_rdata = m_rdata, c_beat = counter.
  - Counter increments after each beat.
  - m_rlast on counter == LINE_BEATS-1: go to DONE.
  - m_rlast early, or beat LINE_BEATS-1 without m_rlast: set err, go to DONE (transaction still closed).
  - Beats outside DATA are ignored and set err.
- DONE:
  - c_done = c_gnt for exactly one cycle.
  - Clear c_gnt; rr_ptr = granted index + 1 (mod NUM_REQ); counter = 0; go to IDLE.
  - A new grant can therefore issue at the earliest 1 cycle after c_done.
- Core disabled mid-transaction: the transaction completes normally; core_en is sampled only in IDLE.
- c_req dropped mid-transaction: the transaction completes; c_done still pulses.
- Simultaneous requests: strict round-robin. No core waits more than NUM_REQ-1 transactions.
- Latency: request seen in IDLE, m_req asserted next cycle. Minimum request-to-c_done = LINE_BEATS+3 cycles with m_ack and m_rvalid held at 1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in ISSUE and DATA and resets on m_ack or m_rvalid.
  - Reaching TIMEOUT: set err, drop m_req, pulse c_done to the granted core, advance rr_ptr, return to IDLE.
  - A late m_rvalid after the abort is ignored and sets err.
- Not defined: no watchdog; the arbiter waits indefinitely in ISSUE/DATA.

Test Plan:
- Single core: core0 req addr 0x1234, m_ack after 2 cycles, 8 beats 0xA0..0xA7 with rlast on beat 7 -> m_addr = 0x1200; c_rvalid[0] on 8 cycles, c_beat 0..7; c_done[0] pulses once; err = 0.
- All four cores requesting continuously, all enabled -> grant order 0,1,2,3,0; each c_done is one cycle; no grant overlap.
- core_en = 4'b0001 with cores 1..3 requesting -> no grant ever issued; after core_en = 4'b1111 the order is 1,2,3.
- m_rlast on beat 5 -> err = 1 sticky; c_done pulses; next request is served normally.
- Reset asserted during beat 3 -> outputs 0 immediately (async); no c_done; first grant after reset goes to core 0.
- ARB_TIMEOUT_EN, TIMEOUT = 16, m_ack never asserted -> m_req drops after 16 cycles; err = 1; c_done pulses; next core is granted.
